// File: rtl/test_harness.sv
// Self-test harness: fills a scratch RAM with an LFSR sequence, regenerates the
// sequence from the seed, reads the RAM back and raises io_success only on a full match.
module test_harness #(
  parameter int          START_DELAY = 8,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] SEED        = 32'h00000001,
  parameter bit          FAULT_EN    = 1'b0,
  parameter int          FAULT_ADDR  = 3
) (
  input  logic clock,
  input  logic reset,
  output logic io_success
);

  localparam int          AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] DLY_LAST  = 32'(START_DELAY - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_FAULT = AW'(FAULT_ADDR);

  typedef enum logic [2:0] {
    IDLE, WRITE, REWIND, READ, DRAIN, PASS, FAIL
  } state_t;

  state_t          state_q;
  logic [31:0]     dly_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     lfsr_q;
  logic            error_q;
  logic            success_q;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     rdata_p1;
  logic [31:0]     exp_p1;
  logic            vld_p1;

  logic [31:0]     wdata_d;
  logic            mismatch_d;

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    lfsr_next = (q >> 1) ^ (q[0] ? 32'h80200003 : 32'h0);
  endfunction

  always_comb begin
    wdata_d = lfsr_q;
    if (FAULT_EN && (addr_q == ADDR_FAULT)) wdata_d = lfsr_q ^ 32'h1;
    mismatch_d = vld_p1 && (rdata_p1 != exp_p1);
  end

  // Stage p0 -> p1: RAM write/read port and expected-value pipeline (data only, not reset)
  always_ff @(posedge clock) begin
    if (state_q == WRITE) mem_q[addr_q] <= wdata_d;
    rdata_p1 <= mem_q[addr_q];
    if (state_q == READ) exp_p1 <= lfsr_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      dly_q     <= 32'd0;
      addr_q    <= '0;
      lfsr_q    <= SEED_EFF;
      error_q   <= 1'b0;
      vld_p1    <= 1'b0;
      success_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dly_q <= dly_q + 32'd1;
          if (dly_q == DLY_LAST) state_q <= WRITE;
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          lfsr_q <= lfsr_next(lfsr_q);
          if (addr_q == ADDR_LAST) state_q <= REWIND;
        end
        REWIND: begin
          lfsr_q  <= SEED_EFF;
          addr_q  <= '0;
          state_q <= READ;
        end
        READ: begin
          vld_p1 <= 1'b1;
          addr_q <= addr_q + 1'b1;
          lfsr_q <= lfsr_next(lfsr_q);
          if (mismatch_d) error_q <= 1'b1;
          if (addr_q == ADDR_LAST) state_q <= DRAIN;
        end
        DRAIN: begin
          vld_p1 <= 1'b0;
          if (error_q || mismatch_d) begin
            error_q <= 1'b1;
            state_q <= FAIL;
          end else begin
            success_q <= 1'b1;
            state_q   <= PASS;
          end
        end
        PASS:    success_q <= 1'b1;
        FAIL:    success_q <= 1'b0;
        default: state_q   <= FAIL;
      endcase
    end
  end

  assign io_success = success_q;

endmodule

// File: tb/tb_test_harness.sv
// Runs four harness configurations off one clock/reset and checks io_success and
// RAM contents against an edge-count model with randomized reset pulses.
module tb_test_harness;

  logic clock;
  logic reset;
  logic s0, s1, s2, s3;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;
  bit started = 1'b0;

  test_harness #(.START_DELAY(8), .DEPTH(16), .SEED(32'h1), .FAULT_EN(1'b0), .FAULT_ADDR(3))
    d0 (.clock(clock), .reset(reset), .io_success(s0));
  test_harness #(.START_DELAY(8), .DEPTH(16), .SEED(32'h1), .FAULT_EN(1'b1), .FAULT_ADDR(3))
    d1 (.clock(clock), .reset(reset), .io_success(s1));
  test_harness #(.START_DELAY(1), .DEPTH(2), .SEED(32'h0), .FAULT_EN(1'b0), .FAULT_ADDR(0))
    d2 (.clock(clock), .reset(reset), .io_success(s2));
  test_harness #(.START_DELAY(3), .DEPTH(8), .SEED(32'hDEADBEEF), .FAULT_EN(1'b0), .FAULT_ADDR(1))
    d3 (.clock(clock), .reset(reset), .io_success(s3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: edges with reset high since the last reset edge
  always @(posedge clock) begin
    if (!reset) begin
      cnt     <= 0;
      started <= 1'b1;
    end else if (cnt < 1000000) begin
      cnt <= cnt + 1;
    end
  end

  function automatic logic [31:0] ref_lfsr(input logic [31:0] q);
    logic [31:0] r;
    r = q >> 1;
    if (q[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic ref_success(input int c, input int sd, input int depth, input bit f);
    return !f && (c >= sd + 2 * depth + 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s edge_cnt=%0d got=%h expected=%h", tag, cnt, obs, exp);
    end
  endtask

  task automatic check_all();
    if (started) begin
      check("d0_success", {31'd0, s0}, {31'd0, ref_success(cnt, 8, 16, 1'b0)});
      check("d1_success", {31'd0, s1}, {31'd0, ref_success(cnt, 8, 16, 1'b1)});
      check("d2_success", {31'd0, s2}, {31'd0, ref_success(cnt, 1, 2, 1'b0)});
      check("d3_success", {31'd0, s3}, {31'd0, ref_success(cnt, 3, 8, 1'b0)});
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      check_all();
    end
  endtask

  task automatic glitch();
    @(negedge clock);
    check_all();
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic probe_mem();
    logic [31:0] lf;
    lf = 32'h1;
    for (int i = 0; i < 16; i++) begin
      check("d0_mem", d0.mem_q[i], lf);
      check("d1_mem", d1.mem_q[i], (i == 3) ? (lf ^ 32'h1) : lf);
      lf = ref_lfsr(lf);
    end
    lf = 32'h1;
    for (int i = 0; i < 2; i++) begin
      check("d2_mem", d2.mem_q[i], lf);
      lf = ref_lfsr(lf);
    end
    lf = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      check("d3_mem", d3.mem_q[i], lf);
      lf = ref_lfsr(lf);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_all();
    reset = 1'b1;
    run(150);
    probe_mem();

    reset = 1'b0;
    run(1);
    reset = 1'b1;
    run(29);
    reset = 1'b0;
    run(1);
    reset = 1'b1;
    run(60);

    reset = 1'b0;
    run(1);
    reset = 1'b1;
    run(10);
    glitch();
    run(50);
    glitch();
    run(5);

    repeat (8) begin
      run($urandom_range(1, 70));
      reset = 1'b0;
      run($urandom_range(1, 3));
      reset = 1'b1;
    end

    reset = 1'b0;
    run(2);
    reset = 1'b1;
    run(1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
